// File: rtl/stopwatch_run_ctrl_if.sv
// Control bundle between the button/switch front end and the stopwatch run sequencer.
// Inputs are one-cycle pulses or levels; outputs are registered status, ticks and display controls.
interface stopwatch_run_ctrl_if;
  logic       btn_pause;
  logic       btn_rst;
  logic       adj_mode;
  logic       adj_sel;
  logic [1:0] state;
  logic       tick_1hz;
  logic       tick_adj;
  logic       clr;
  logic       blink;
  logic       blank_min;
  logic       blank_sec;

  modport master (
    output btn_pause, btn_rst, adj_mode, adj_sel,
    input  state, tick_1hz, tick_adj, clr, blink, blank_min, blank_sec
  );

  modport slave (
    input  btn_pause, btn_rst, adj_mode, adj_sel,
    output state, tick_1hz, tick_adj, clr, blink, blank_min, blank_sec
  );
endinterface

// File: rtl/stopwatch_run_ctrl.sv
// Stopwatch run control: owns the quarter-second divider, emits 1 Hz / 2 Hz ticks, clear and blink.
// Latency 1 cycle, every output registered; no backpressure, pulses are fire-and-forget.
module stopwatch_run_ctrl #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int DIV_WIDTH = 25
) (
  input  logic                src_clk,
  input  logic                src_rst_n,
  stopwatch_run_ctrl_if.slave ctl
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_ADJ   = 2'b11
  } state_t;

  localparam logic [DIV_WIDTH-1:0] QCNT_LAST = DIV_WIDTH'(CLK_HZ / 4 - 1);

  state_t               st_q, st_d;
  logic [DIV_WIDTH-1:0] qcnt_q, qcnt_d;
  logic [1:0]           qph_q, qph_d;
  logic                 tick_1hz_q, tick_1hz_d;
  logic                 tick_adj_q, tick_adj_d;
  logic                 clr_q, clr_d;
  logic                 blink_q, blink_d;
  logic                 blank_min_q, blank_min_d;
  logic                 blank_sec_q, blank_sec_d;
  logic                 div_clr, counting, qe, stay;

  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) st_q <= ST_IDLE;
    else            st_q <= st_d;
  end

  always_comb begin
    st_d        = st_q;
    qcnt_d      = qcnt_q;
    qph_d       = qph_q;
    tick_1hz_d  = 1'b0;
    tick_adj_d  = 1'b0;
    clr_d       = ctl.btn_rst;
    blink_d     = blink_q;
    blank_min_d = 1'b0;
    blank_sec_d = 1'b0;

    // Reset beats adjust, adjust beats start/pause.
    if (ctl.btn_rst) begin
      st_d = ctl.adj_mode ? ST_ADJ : ST_IDLE;
    end else begin
      case (st_q)
        ST_IDLE:  if (ctl.adj_mode) st_d = ST_ADJ; else if (ctl.btn_pause) st_d = ST_RUN;
        ST_RUN:   if (ctl.adj_mode) st_d = ST_ADJ; else if (ctl.btn_pause) st_d = ST_PAUSE;
        ST_PAUSE: if (ctl.adj_mode) st_d = ST_ADJ; else if (ctl.btn_pause) st_d = ST_RUN;
        ST_ADJ:   if (!ctl.adj_mode) st_d = ST_PAUSE;
        default:  st_d = ST_IDLE;
      endcase
    end

    stay     = (st_d == st_q);
    div_clr  = ctl.btn_rst | ((st_q == ST_ADJ) != (st_d == ST_ADJ));
    counting = (st_q == ST_RUN) || (st_q == ST_ADJ);
    qe       = counting && !div_clr && (qcnt_q == QCNT_LAST);

    // PAUSE falls through both branches, so the partial second is held.
    if (div_clr || st_q == ST_IDLE) begin
      qcnt_d = '0;
      qph_d  = '0;
    end else if (counting) begin
      qcnt_d = qe ? '0 : qcnt_q + DIV_WIDTH'(1);
      if (qe) qph_d = qph_q + 2'd1;
    end

    tick_1hz_d = qe && stay && (st_q == ST_RUN) && (qph_q == 2'd3);
    tick_adj_d = qe && stay && (st_q == ST_ADJ) && qph_q[0];

    if (st_d == ST_IDLE || (st_q == ST_ADJ && st_d != ST_ADJ)) blink_d = 1'b0;
    else if (qe && stay && st_q == ST_ADJ)                     blink_d = ~blink_q;

    blank_min_d = (st_d == ST_ADJ) && !ctl.adj_sel && blink_d;
    blank_sec_d = (st_d == ST_ADJ) &&  ctl.adj_sel && blink_d;
  end

  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      qcnt_q      <= '0;
      qph_q       <= '0;
      tick_1hz_q  <= 1'b0;
      tick_adj_q  <= 1'b0;
      clr_q       <= 1'b0;
      blink_q     <= 1'b0;
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
    end else begin
      qcnt_q      <= qcnt_d;
      qph_q       <= qph_d;
      tick_1hz_q  <= tick_1hz_d;
      tick_adj_q  <= tick_adj_d;
      clr_q       <= clr_d;
      blink_q     <= blink_d;
      blank_min_q <= blank_min_d;
      blank_sec_q <= blank_sec_d;
    end
  end

  assign ctl.state     = st_q;
  assign ctl.tick_1hz  = tick_1hz_q;
  assign ctl.tick_adj  = tick_adj_q;
  assign ctl.clr       = clr_q;
  assign ctl.blink     = blink_q;
  assign ctl.blank_min = blank_min_q;
  assign ctl.blank_sec = blank_sec_q;

endmodule

// File: doc/stopwatch_run_ctrl.md
Name: stopwatch_run_ctrl

Overview:
Run-control sequencer for the stopwatch. It owns the single shared timebase divider and decides when the divider runs, freezes or clears, based on one-cycle button pulses and the adjust-mode switch. It emits one-cycle tick enables for the digit counters: 1 Hz when running, 2 Hz when adjusting. It also emits a clear pulse and blink/blank controls for the display driver.

Parameters:
CLK_HZ, 100000000, src_clk frequency in Hz; must be divisible by 4 and at least 8.
DIV_WIDTH, 25, width of the quarter-second divider; must satisfy 2^DIV_WIDTH >= CLK_HZ/4.

Ports:
src_clk  input  1  system clock.
src_rst_n  input  1  asynchronous active-low reset.
btn_pause  input  1  debounced one-cycle pulse; start/pause toggle.
btn_rst  input  1  debounced one-cycle pulse; clear stopwatch.
adj_mode  input  1  level; 1 = adjust mode.
adj_sel  input  1  level; 0 = adjust minutes, 1 = adjust seconds.
state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 ADJUST.
tick_1hz  output  1  one-cycle count enable, RUN only.
tick_adj  output  1  one-cycle adjust increment, 2 Hz, ADJUST only.
clr  output  1  one-cycle clear pulse to the digit counters.
blink  output  1  2 Hz square wave (toggles every quarter second).
blank_min  output  1  blank the minute digits.
blank_sec  output  1  blank the second digits.

Behaviour:
- Reset (src_rst_n=0, asynchronous): state=IDLE; divider, quarter counter, tick_1hz, tick_adj, clr, blink, blank_min and blank_sec all 0. Reset mid-operation aborts immediately; no pending tick survives.
- All outputs are registered. An input sampled at edge N is reflected in outputs after edge N (1-cycle latency).
- Divider qcnt (DIV_WIDTH bits):
  - Counts 0..Q-1, where Q=CLK_HZ/4. Quarter event qe = (qcnt==Q-1), then qcnt wraps to 0.
  - A 2-bit quarter counter qph increments on each qe and wraps 3->0.
- Divider control by state:
  - RUN, ADJUST: divider counts.
  - PAUSE: divider and qph freeze and hold their values (partial second preserved).
  - IDLE: divider and qph held at 0.
  - Cleared to 0 on: entry to ADJUST, exit from ADJUST, and any clr.
- Transition priority per cycle: btn_rst > adj_mode > btn_pause.
  - btn_rst in any state: clr=1 next cycle; state->IDLE, or ->ADJUST if adj_mode=1.
  - IDLE: adj_mode=1 -> ADJUST; else btn_pause -> RUN.
  - RUN: adj_mode=1 -> ADJUST; else btn_pause -> PAUSE.
  - PAUSE: adj_mode=1 -> ADJUST; else btn_pause -> RUN.
  - ADJUST: adj_mode=0 -> PAUSE (adjusted value kept; start with btn_pause). btn_pause ignored.
- tick_1hz: high for exactly one cycle after qe with qph==3 while state==RUN. First tick arrives CLK_HZ RUN-cycles after leaving IDLE; pause time is excluded.
- tick_adj: high one cycle after qe with qph odd, while state==ADJUST (every CLK_HZ/2 cycles).
- No tick_1hz or tick_adj is issued in the cycle clr is high, or in the cycle state changes.
- blink:
  - Toggles on each qe in ADJUST; holds its value in RUN and PAUSE.
  - Forced to 0 in IDLE and on ADJUST exit.
- Blanking:
  - blank_min = (state==ADJUST) & ~adj_sel & blink.
  - blank_sec = (state==ADJUST) & adj_sel & blink.
  - Both are registered alongside state.
- adj_sel changes while in ADJUST take effect the next cycle; the divider is not disturbed.
- btn_pause and btn_rst in the same cycle: btn_rst wins, btn_pause is dropped.

Test Plan (CLK_HZ=16, Q=4):
- Reset release, no inputs for 100 cycles -> state=00; tick_1hz, tick_adj and clr never asserted; blanks 0.
- btn_pause at cycle 10 -> state=01 from cycle 11; tick_1hz pulses at cycles 27, 43, 59 (period 16, width 1).
- RUN 10 cycles, btn_pause (PAUSE) held for 50 cycles, btn_pause again -> next tick_1hz arrives 6 RUN-cycles after resume; no ticks during PAUSE.
- adj_mode=1 from RUN -> state=11 next cycle; tick_adj every 8 cycles; blink toggles every 4 cycles. adj_sel=0 gives blank_min=blink and blank_sec=0; flip adj_sel -> blanks swap. adj_mode=0 -> state=10, blink=0, no ticks.
- btn_pause and btn_rst together in RUN -> clr=1 for one cycle, state=00, divider 0, no tick that cycle. Repeat with adj_mode=1 -> state=11 after the clr pulse.
- Assert src_rst_n low mid-count, asynchronously between edges -> all outputs 0 immediately. After release, the first tick_1hz requires a fresh btn_pause plus 16 cycles.
